// File: rtl/sram_1rw1r_arb.sv
// ============================================================================
// sram_1rw1r_arb
//
// Arbitration and response buffering in front of a dual-port SRAM macro that
// has one read/write port (port 0) and one read-only port (port 1). Both ports
// use the same clock.
//
// Two read/write masters share port 0 through a round-robin arbiter. Each
// master gets a 2-entry response FIFO. A separate read-only channel owns
// port 1 and has its own 2-entry response FIFO.
//
// Timing for a command granted or accepted in cycle N:
//   N    : the SRAM port is driven with chip select, address and data.
//   N+1  : the macro presents read data, captured at the end of the cycle.
//   N+2+ : the response is at the head of the FIFO (or queued behind older
//          ones) until the master pops it.
//
// Ports
//   clk, rst                    single clock, asynchronous active-high reset
//   m_cmd_valid/ready[1:0]      per-master command handshake (bit i = master i)
//   m_cmd_read[1:0]             1 = read, 0 = write
//   m_cmd_addr  [2*AW]          word address, master i at [i*AW +: AW]
//   m_cmd_wdata [2*DW]          write data
//   m_cmd_wmask [2*MW]          byte enables
//   m_rsp_valid/ready[1:0]      per-master response handshake
//   m_rsp_rdata [2*DW]          read data, zero for write responses
//   rd_cmd_valid/ready/addr     read-only channel command
//   rd_rsp_valid/ready/rdata    read-only channel response
//   sram_*0                     SRAM port 0 (read/write), active-low csb/web
//   sram_*1                     SRAM port 1 (read-only), active-low csb
// ============================================================================
module sram_1rw1r_arb #(
    parameter int AW = 13,
    parameter int DW = 32,
    parameter int MW = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [1:0]      m_cmd_valid,
    output logic [1:0]      m_cmd_ready,
    input  logic [1:0]      m_cmd_read,
    input  logic [2*AW-1:0] m_cmd_addr,
    input  logic [2*DW-1:0] m_cmd_wdata,
    input  logic [2*MW-1:0] m_cmd_wmask,
    output logic [1:0]      m_rsp_valid,
    input  logic [1:0]      m_rsp_ready,
    output logic [2*DW-1:0] m_rsp_rdata,

    input  logic            rd_cmd_valid,
    output logic            rd_cmd_ready,
    input  logic [AW-1:0]   rd_cmd_addr,
    output logic            rd_rsp_valid,
    input  logic            rd_rsp_ready,
    output logic [DW-1:0]   rd_rsp_rdata,

    output logic            sram_csb0,
    output logic            sram_web0,
    output logic [MW-1:0]   sram_wmask0,
    output logic [AW-1:0]   sram_addr0,
    output logic [DW-1:0]   sram_din0,
    input  logic [DW-1:0]   sram_dout0,

    output logic            sram_csb1,
    output logic [AW-1:0]   sram_addr1,
    input  logic [DW-1:0]   sram_dout1
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Round-robin priority pointer: master that wins when both are eligible.
    logic            r_prio;

    // Port-0 pipeline stage: a grant from the previous cycle whose SRAM data
    // is on sram_dout0 this cycle.
    logic            r_p0Vld;
    logic            r_p0Mst;
    logic            r_p0Rd;

    // Port-1 pipeline stage: an accepted read whose data is on sram_dout1.
    logic            r_p1Vld;

    // Per-master outstanding count (granted but not yet popped) and the
    // 2-entry response FIFO.
    logic [1:0]      r_mOut  [2];
    logic [1:0]      r_mCnt  [2];
    logic [DW-1:0]   r_mData [2][2];
    logic [1:0]      r_mWp;
    logic [1:0]      r_mRp;

    // Read-only channel outstanding count and FIFO.
    logic [1:0]      r_rOut;
    logic [1:0]      r_rCnt;
    logic [DW-1:0]   r_rData [2];
    logic            r_rWp;
    logic            r_rRp;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [1:0]      w_mPop;
    logic [1:0]      w_elig;
    logic [1:0]      w_grant;
    logic            w_gValid;
    logic            w_gIdx;
    logic [1:0]      w_mPush;
    logic [DW-1:0]   w_p0Data;
    logic            w_rdPop;
    logic            w_hazard;
    logic            w_rdAcc;

    // ------------------------------------------------------------------------
    // Response-side views of the FIFOs. Data is forced to zero whenever a
    // FIFO is empty so that nothing stale leaks out, in particular right
    // after reset clears the counts.
    // ------------------------------------------------------------------------
    always_comb begin
        m_rsp_valid = 2'b00;
        m_rsp_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            m_rsp_valid[i] = (r_mCnt[i] != 2'd0);
            if (r_mCnt[i] != 2'd0) begin
                m_rsp_rdata[i*DW +: DW] = r_mData[i][r_mRp[i]];
            end
        end
    end

    assign rd_rsp_valid = (r_rCnt != 2'd0);
    assign rd_rsp_rdata = (r_rCnt != 2'd0) ? r_rData[r_rRp] : '0;

    assign w_mPop  = m_rsp_valid & m_rsp_ready;
    assign w_rdPop = rd_rsp_valid & rd_rsp_ready;

    // ------------------------------------------------------------------------
    // Eligibility. A master may hold at most two outstanding commands, but a
    // pop in the same cycle frees a slot, so back-to-back traffic keeps
    // flowing at full rate while the master drains its responses.
    // ------------------------------------------------------------------------
    always_comb begin
        w_elig = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_elig[i] = !rst && m_cmd_valid[i] &&
                        ((r_mOut[i] != 2'd2) || w_mPop[i]);
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin arbiter: contention resolved by the pointer, otherwise the
    // single eligible master wins. At most one grant per cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant = 2'b00;
        if (w_elig == 2'b11) begin
            w_grant = r_prio ? 2'b10 : 2'b01;
        end else begin
            w_grant = w_elig;
        end
    end

    assign w_gValid    = |w_grant;
    assign w_gIdx      = w_grant[1];
    assign m_cmd_ready = w_grant;

    // ------------------------------------------------------------------------
    // SRAM port 0 drive. Idle (and reset) drives the inactive levels and
    // zeroes on address and data so the macro sees quiet inputs.
    // ------------------------------------------------------------------------
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (w_gValid) begin
            sram_csb0   = 1'b0;
            sram_web0   = m_cmd_read[w_gIdx];
            sram_wmask0 = w_gIdx ? m_cmd_wmask[2*MW-1:MW] : m_cmd_wmask[MW-1:0];
            sram_addr0  = w_gIdx ? m_cmd_addr[2*AW-1:AW]  : m_cmd_addr[AW-1:0];
            sram_din0   = w_gIdx ? m_cmd_wdata[2*DW-1:DW] : m_cmd_wdata[DW-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Read-only channel acceptance. A port-0 write to the address being read
    // on port 1 in the same cycle would give undefined read data from the
    // macro, so the read is held off for that one cycle and then sees the
    // freshly written word. Same-address reads on both ports are harmless.
    // ------------------------------------------------------------------------
    assign w_hazard     = w_gValid && !sram_web0 && (sram_addr0 == rd_cmd_addr);
    assign rd_cmd_ready = !rst && !w_hazard &&
                          ((r_rOut != 2'd2) || w_rdPop);
    assign w_rdAcc      = rd_cmd_valid && rd_cmd_ready;

    assign sram_csb1    = !w_rdAcc;
    assign sram_addr1   = w_rdAcc ? rd_cmd_addr : '0;

    // ------------------------------------------------------------------------
    // Steering of port-0 data into the per-master FIFOs. Writes return a
    // zero data word so every command gets exactly one response.
    // ------------------------------------------------------------------------
    assign w_mPush  = r_p0Vld ? (r_p0Mst ? 2'b10 : 2'b01) : 2'b00;
    assign w_p0Data = r_p0Rd ? sram_dout0 : '0;

    // ------------------------------------------------------------------------
    // Master-side state: priority pointer, port-0 pipeline stage,
    // outstanding counts and response FIFOs. Reset drops everything in
    // flight or buffered and hands priority back to master 0.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio  <= 1'b0;
            r_p0Vld <= 1'b0;
            r_p0Mst <= 1'b0;
            r_p0Rd  <= 1'b0;
            r_mWp   <= 2'b00;
            r_mRp   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_mOut[i]     <= 2'd0;
                r_mCnt[i]     <= 2'd0;
                r_mData[i][0] <= '0;
                r_mData[i][1] <= '0;
            end
        end else begin
            if (w_gValid) begin
                r_prio <= !w_gIdx;
            end
            r_p0Vld <= w_gValid;
            r_p0Mst <= w_gIdx;
            r_p0Rd  <= sram_web0;
            for (int i = 0; i < 2; i++) begin
                if (w_mPush[i]) begin
                    r_mData[i][r_mWp[i]] <= w_p0Data;
                    r_mWp[i]             <= !r_mWp[i];
                end
                if (w_mPop[i]) begin
                    r_mRp[i] <= !r_mRp[i];
                end
                r_mCnt[i] <= r_mCnt[i] + {1'b0, w_mPush[i]} - {1'b0, w_mPop[i]};
                r_mOut[i] <= r_mOut[i] + {1'b0, w_grant[i]} - {1'b0, w_mPop[i]};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read-only channel state: port-1 pipeline stage, outstanding count and
    // response FIFO.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1Vld    <= 1'b0;
            r_rOut     <= 2'd0;
            r_rCnt     <= 2'd0;
            r_rWp      <= 1'b0;
            r_rRp      <= 1'b0;
            r_rData[0] <= '0;
            r_rData[1] <= '0;
        end else begin
            r_p1Vld <= w_rdAcc;
            if (r_p1Vld) begin
                r_rData[r_rWp] <= sram_dout1;
                r_rWp          <= !r_rWp;
            end
            if (w_rdPop) begin
                r_rRp <= !r_rRp;
            end
            r_rCnt <= r_rCnt + {1'b0, r_p1Vld} - {1'b0, w_rdPop};
            r_rOut <= r_rOut + {1'b0, w_rdAcc} - {1'b0, w_rdPop};
        end
    end

endmodule

// File: tb/tb_sram_1rw1r_arb.sv
// ============================================================================
// tb_sram_1rw1r_arb
//
// Directed bench for sram_1rw1r_arb with a behavioural dual-port SRAM model.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
// Unwritten SRAM words read as 0x10000000 | address.
// ============================================================================
module tb_sram_1rw1r_arb;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int MW = 4;

    logic            clk;
    logic            rst;
    logic [1:0]      m_cmd_valid;
    logic [1:0]      m_cmd_ready;
    logic [1:0]      m_cmd_read;
    logic [2*AW-1:0] m_cmd_addr;
    logic [2*DW-1:0] m_cmd_wdata;
    logic [2*MW-1:0] m_cmd_wmask;
    logic [1:0]      m_rsp_valid;
    logic [1:0]      m_rsp_ready;
    logic [2*DW-1:0] m_rsp_rdata;
    logic            rd_cmd_valid;
    logic            rd_cmd_ready;
    logic [AW-1:0]   rd_cmd_addr;
    logic            rd_rsp_valid;
    logic            rd_rsp_ready;
    logic [DW-1:0]   rd_rsp_rdata;
    logic            sram_csb0;
    logic            sram_web0;
    logic [MW-1:0]   sram_wmask0;
    logic [AW-1:0]   sram_addr0;
    logic [DW-1:0]   sram_din0;
    logic [DW-1:0]   sram_dout0;
    logic            sram_csb1;
    logic [AW-1:0]   sram_addr1;
    logic [DW-1:0]   sram_dout1;

    int checkCount = 0;
    int failCount  = 0;

    sram_1rw1r_arb #(.AW(AW), .DW(DW), .MW(MW)) dut (
        .clk          (clk),
        .rst          (rst),
        .m_cmd_valid  (m_cmd_valid),
        .m_cmd_ready  (m_cmd_ready),
        .m_cmd_read   (m_cmd_read),
        .m_cmd_addr   (m_cmd_addr),
        .m_cmd_wdata  (m_cmd_wdata),
        .m_cmd_wmask  (m_cmd_wmask),
        .m_rsp_valid  (m_rsp_valid),
        .m_rsp_ready  (m_rsp_ready),
        .m_rsp_rdata  (m_rsp_rdata),
        .rd_cmd_valid (rd_cmd_valid),
        .rd_cmd_ready (rd_cmd_ready),
        .rd_cmd_addr  (rd_cmd_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_rsp_rdata (rd_rsp_rdata),
        .sram_csb0    (sram_csb0),
        .sram_web0    (sram_web0),
        .sram_wmask0  (sram_wmask0),
        .sram_addr0   (sram_addr0),
        .sram_din0    (sram_din0),
        .sram_dout0   (sram_dout0),
        .sram_csb1    (sram_csb1),
        .sram_addr1   (sram_addr1),
        .sram_dout1   (sram_dout1)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    // Behavioural SRAM: registered reads on both ports, byte-masked writes
    logic [DW-1:0] mem [int];

    function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
        return 32'h1000_0000 | {19'b0, a};
    endfunction

    function automatic logic [DW-1:0] memRead(input logic [AW-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return initVal(a);
    endfunction

    always @(posedge clk) begin
        logic [DW-1:0] word;
        if (!sram_csb1) begin
            sram_dout1 <= memRead(sram_addr1);
        end
        if (!sram_csb0) begin
            if (sram_web0) begin
                sram_dout0 <= memRead(sram_addr0);
            end else begin
                word = memRead(sram_addr0);
                for (int b = 0; b < MW; b++) begin
                    if (sram_wmask0[b]) word[b*8 +: 8] = sram_din0[b*8 +: 8];
                end
                mem[int'(sram_addr0)] = word;
            end
        end
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [63:0] act,
                               input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then settle for sampling
    task automatic applyStimulus(input logic [1:0] mValid, input logic [1:0] mRead,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] wd0, input logic [MW-1:0] wm0,
                                 input logic [1:0] rspRdy, input logic rdValid,
                                 input logic [AW-1:0] rdAddr, input logic rdRspRdy);
        @(negedge clk);
        m_cmd_valid  = mValid;
        m_cmd_read   = mRead;
        m_cmd_addr   = {a1, a0};
        m_cmd_wdata  = {32'h0BAD_0BAD, wd0};
        m_cmd_wmask  = {4'hF, wm0};
        m_rsp_ready  = rspRdy;
        rd_cmd_valid = rdValid;
        rd_cmd_addr  = rdAddr;
        rd_rsp_ready = rdRspRdy;
        #1;
    endtask

    task automatic idleCycle(input logic [1:0] rspRdy, input logic rdRspRdy);
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, rspRdy, 1'b0, '0, rdRspRdy);
    endtask

    // Full set of reset-level checks
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_cmd_ready"}, 64'(m_cmd_ready), 64'd0);
        checkOutput({tag, "_rd_ready"},  64'(rd_cmd_ready), 64'd0);
        checkOutput({tag, "_rsp_valid"}, 64'(m_rsp_valid), 64'd0);
        checkOutput({tag, "_rd_valid"},  64'(rd_rsp_valid), 64'd0);
        checkOutput({tag, "_rsp_rdata"}, 64'(m_rsp_rdata), 64'd0);
        checkOutput({tag, "_rd_rdata"},  64'(rd_rsp_rdata), 64'd0);
        checkOutput({tag, "_csb0"},      64'(sram_csb0), 64'd1);
        checkOutput({tag, "_csb1"},      64'(sram_csb1), 64'd1);
        checkOutput({tag, "_web0"},      64'(sram_web0), 64'd1);
        checkOutput({tag, "_wmask0"},    64'(sram_wmask0), 64'd0);
        checkOutput({tag, "_addr0"},     64'(sram_addr0), 64'd0);
        checkOutput({tag, "_addr1"},     64'(sram_addr1), 64'd0);
        checkOutput({tag, "_din0"},      64'(sram_din0), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        // Busy inputs during reset must not leak through
        applyStimulus(2'b11, 2'b00, 13'h005, 13'h006, 32'h1234_5678, 4'hF,
                      2'b11, 1'b1, 13'h007, 1'b1);
        checkResetOutputs("reset");
        idleCycle(2'b11, 1'b1);
        rst = 1'b0;

        // ---- Round-robin with both masters requesting every cycle ----
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b11, 2'b11, 13'(16'h100 + k), 13'(16'h200 + k), '0, '0,
                          2'b11, 1'b0, '0, 1'b1);
            checkOutput($sformatf("rr_grant%0d", k), 64'(m_cmd_ready),
                        (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k == 2) begin
                checkOutput("rr_rspv2", 64'(m_rsp_valid), 64'd1);
                checkOutput("rr_m0data", 64'(m_rsp_rdata[31:0]), 64'h1000_0100);
            end
            if (k == 3) begin
                checkOutput("rr_rspv3", 64'(m_rsp_valid), 64'd2);
                checkOutput("rr_m1data", 64'(m_rsp_rdata[63:32]), 64'h1000_0201);
            end
        end
        idleCycle(2'b11, 1'b1);
        checkOutput("rr_rspv4", 64'(m_rsp_valid), 64'd1);
        checkOutput("rr_m0data2", 64'(m_rsp_rdata[31:0]), 64'h1000_0102);
        idleCycle(2'b11, 1'b1);
        checkOutput("rr_rspv5", 64'(m_rsp_valid), 64'd2);
        checkOutput("rr_m1data2", 64'(m_rsp_rdata[63:32]), 64'h1000_0203);
        idleCycle(2'b11, 1'b1);
        checkOutput("rr_drained", 64'(m_rsp_valid), 64'd0);

        // ---- m0 write then read back ----
        applyStimulus(2'b01, 2'b00, 13'h010, '0, 32'hDEAD_BEEF, 4'hF, 2'b11, 1'b0, '0, 1'b1);
        checkOutput("wr_ready", 64'(m_cmd_ready), 64'd1);
        checkOutput("wr_csb0", 64'(sram_csb0), 64'd0);
        checkOutput("wr_web0", 64'(sram_web0), 64'd0);
        checkOutput("wr_addr0", 64'(sram_addr0), 64'h010);
        checkOutput("wr_din0", 64'(sram_din0), 64'hDEAD_BEEF);
        checkOutput("wr_wmask0", 64'(sram_wmask0), 64'hF);
        applyStimulus(2'b01, 2'b01, 13'h010, '0, '0, '0, 2'b11, 1'b0, '0, 1'b1);
        checkOutput("rdb_ready", 64'(m_cmd_ready), 64'd1);
        checkOutput("rdb_web0", 64'(sram_web0), 64'd1);
        checkOutput("rdb_rspv_n1", 64'(m_rsp_valid), 64'd0);
        idleCycle(2'b11, 1'b1);
        checkOutput("wrsp_valid", 64'(m_rsp_valid), 64'd1);
        checkOutput("wrsp_rdata", 64'(m_rsp_rdata[31:0]), 64'd0);
        idleCycle(2'b11, 1'b1);
        checkOutput("rrsp_valid", 64'(m_rsp_valid), 64'd1);
        checkOutput("rrsp_rdata", 64'(m_rsp_rdata[31:0]), 64'hDEAD_BEEF);
        idleCycle(2'b11, 1'b1);
        checkOutput("rrsp_done", 64'(m_rsp_valid), 64'd0);

        // ---- m1 back-pressure: third read stalls until first pop ----
        applyStimulus(2'b10, 2'b10, '0, 13'h300, '0, '0, 2'b01, 1'b0, '0, 1'b1);
        checkOutput("bp_acc0", 64'(m_cmd_ready), 64'd2);
        applyStimulus(2'b10, 2'b10, '0, 13'h301, '0, '0, 2'b01, 1'b0, '0, 1'b1);
        checkOutput("bp_acc1", 64'(m_cmd_ready), 64'd2);
        applyStimulus(2'b10, 2'b10, '0, 13'h302, '0, '0, 2'b01, 1'b0, '0, 1'b1);
        checkOutput("bp_stall0", 64'(m_cmd_ready), 64'd0);
        checkOutput("bp_rspv", 64'(m_rsp_valid), 64'd2);
        checkOutput("bp_head0", 64'(m_rsp_rdata[63:32]), 64'h1000_0300);
        applyStimulus(2'b10, 2'b10, '0, 13'h302, '0, '0, 2'b01, 1'b0, '0, 1'b1);
        checkOutput("bp_stall1", 64'(m_cmd_ready), 64'd0);
        checkOutput("bp_hold", 64'(m_rsp_rdata[63:32]), 64'h1000_0300);
        applyStimulus(2'b10, 2'b10, '0, 13'h302, '0, '0, 2'b11, 1'b0, '0, 1'b1);
        checkOutput("bp_acc2", 64'(m_cmd_ready), 64'd2);
        checkOutput("bp_pop0", 64'(m_rsp_rdata[63:32]), 64'h1000_0300);
        idleCycle(2'b01, 1'b1);
        checkOutput("bp_rspv1", 64'(m_rsp_valid), 64'd2);
        checkOutput("bp_head1", 64'(m_rsp_rdata[63:32]), 64'h1000_0301);
        idleCycle(2'b11, 1'b1);
        checkOutput("bp_pop1", 64'(m_rsp_rdata[63:32]), 64'h1000_0301);
        idleCycle(2'b11, 1'b1);
        checkOutput("bp_rspv2", 64'(m_rsp_valid), 64'd2);
        checkOutput("bp_head2", 64'(m_rsp_rdata[63:32]), 64'h1000_0302);
        idleCycle(2'b11, 1'b1);
        checkOutput("bp_empty", 64'(m_rsp_valid), 64'd0);

        // ---- Masked write, then same-address read on both ports ----
        applyStimulus(2'b01, 2'b00, 13'h020, '0, 32'h1122_3344, 4'h5, 2'b11, 1'b0, '0, 1'b1);
        checkOutput("mw_ready", 64'(m_cmd_ready), 64'd1);
        applyStimulus(2'b01, 2'b01, 13'h020, '0, '0, '0, 2'b11, 1'b1, 13'h020, 1'b1);
        checkOutput("dual_m0ready", 64'(m_cmd_ready), 64'd1);
        checkOutput("dual_rdready", 64'(rd_cmd_ready), 64'd1);
        checkOutput("dual_csb1", 64'(sram_csb1), 64'd0);
        checkOutput("dual_addr1", 64'(sram_addr1), 64'h020);
        idleCycle(2'b11, 1'b1);
        checkOutput("mw_wrsp", 64'(m_rsp_rdata[31:0]), 64'd0);
        checkOutput("dual_rdv_early", 64'(rd_rsp_valid), 64'd0);
        idleCycle(2'b11, 1'b1);
        checkOutput("dual_m0data", 64'(m_rsp_rdata[31:0]), 64'h1022_0044);
        checkOutput("dual_rdvalid", 64'(rd_rsp_valid), 64'd1);
        checkOutput("dual_rddata", 64'(rd_rsp_rdata), 64'h1022_0044);
        idleCycle(2'b11, 1'b1);
        checkOutput("dual_rdempty", 64'(rd_rsp_valid), 64'd0);

        // ---- Write/read hazard at the top address ----
        applyStimulus(2'b01, 2'b00, 13'h1FFF, '0, 32'hCAFE_F00D, 4'hF, 2'b11, 1'b1, 13'h1FFF, 1'b1);
        checkOutput("hz_m0ready", 64'(m_cmd_ready), 64'd1);
        checkOutput("hz_rdblock", 64'(rd_cmd_ready), 64'd0);
        checkOutput("hz_csb1", 64'(sram_csb1), 64'd1);
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b11, 1'b1, 13'h1FFF, 1'b1);
        checkOutput("hz_rdaccept", 64'(rd_cmd_ready), 64'd1);
        checkOutput("hz_csb1_go", 64'(sram_csb1), 64'd0);
        idleCycle(2'b11, 1'b1);
        checkOutput("hz_rdv_early", 64'(rd_rsp_valid), 64'd0);
        checkOutput("hz_wrsp", 64'(m_rsp_valid), 64'd1);
        idleCycle(2'b11, 1'b1);
        checkOutput("hz_rdvalid", 64'(rd_rsp_valid), 64'd1);
        checkOutput("hz_rddata", 64'(rd_rsp_rdata), 64'hCAFE_F00D);

        // ---- Reset with buffered responses ----
        applyStimulus(2'b01, 2'b01, 13'h040, '0, '0, '0, 2'b00, 1'b1, 13'h050, 1'b0);
        checkOutput("rs_acc0", 64'(m_cmd_ready), 64'd1);
        applyStimulus(2'b01, 2'b01, 13'h041, '0, '0, '0, 2'b00, 1'b1, 13'h051, 1'b0);
        checkOutput("rs_acc1", 64'(m_cmd_ready), 64'd1);
        checkOutput("rs_rdacc1", 64'(rd_cmd_ready), 64'd1);
        idleCycle(2'b00, 1'b0);
        checkOutput("rs_buf_rdata", 64'(m_rsp_rdata[31:0]), 64'h1000_0040);
        applyStimulus(2'b01, 2'b01, 13'h060, '0, '0, '0, 2'b00, 1'b1, 13'h080, 1'b0);
        checkOutput("rs_full_m0", 64'(m_cmd_ready), 64'd0);
        checkOutput("rs_full_rd", 64'(rd_cmd_ready), 64'd0);
        checkOutput("rs_buffered", 64'(m_rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        checkResetOutputs("rs_mid");
        idleCycle(2'b11, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("rs_rel_rspv", 64'(m_rsp_valid), 64'd0);
        checkOutput("rs_rel_rdv", 64'(rd_rsp_valid), 64'd0);
        applyStimulus(2'b11, 2'b11, 13'h090, 13'h0A0, '0, '0, 2'b11, 1'b1, 13'h0B0, 1'b1);
        checkOutput("rs_prio_m0", 64'(m_cmd_ready), 64'd1);
        checkOutput("rs_rd_free", 64'(rd_cmd_ready), 64'd1);
        idleCycle(2'b11, 1'b1);
        checkOutput("rs_nostale", 64'(m_rsp_valid), 64'd0);
        checkOutput("rs_nostale_rd", 64'(rd_rsp_valid), 64'd0);
        idleCycle(2'b11, 1'b1);
        checkOutput("rs_fresh_v", 64'(m_rsp_valid), 64'd1);
        checkOutput("rs_fresh_d", 64'(m_rsp_rdata[31:0]), 64'h1000_0090);
        checkOutput("rs_fresh_rd", 64'(rd_rsp_rdata), 64'h1000_00B0);
        idleCycle(2'b11, 1'b1);
        checkOutput("rs_end", 64'(m_rsp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/sram_1rw1r_arb.md
SRAM_1RW1R_ARB -- requirements
Module: sram_1rw1r_arb

Interface
REQ-001 SHALL have parameter AW, default 13, SRAM word address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MW, default 4, byte write-mask width (DW/8).
REQ-004 SHALL have port clk  in  1  single clock for block and attached SRAM (clk0 and clk1).
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port m_cmd_valid  in  2  per-master RW command valid; bit i = master i.
REQ-007 SHALL have port m_cmd_ready  out  2  per-master command accept.
REQ-008 SHALL have port m_cmd_read  in  2  1 = read, 0 = write.
REQ-009 SHALL have port m_cmd_addr  in  2*AW  word addresses; master i at [i*AW +: AW].
REQ-010 SHALL have port m_cmd_wdata  in  2*DW  write data.
REQ-011 SHALL have port m_cmd_wmask  in  2*MW  byte enables.
REQ-012 SHALL have port m_rsp_valid  out  2  response valid.
REQ-013 SHALL have port m_rsp_ready  in  2  response accept.
REQ-014 SHALL have port m_rsp_rdata  out  2*DW  read data; 0 for write responses.
REQ-015 SHALL have port rd_cmd_valid  in  1  read-only channel command valid.
REQ-016 SHALL have port rd_cmd_ready  out  1  read-only channel accept.
REQ-017 SHALL have port rd_cmd_addr  in  AW  read-only channel address.
REQ-018 SHALL have port rd_rsp_valid  out  1  read-only response valid.
REQ-019 SHALL have port rd_rsp_ready  in  1  read-only response accept.
REQ-020 SHALL have port rd_rsp_rdata  out  DW  read-only response data.
REQ-021 SHALL have port sram_csb0  out  1  SRAM port-0 chip select, active-low.
REQ-022 SHALL have port sram_web0  out  1  SRAM port-0 write enable, active-low.
REQ-023 SHALL have port sram_wmask0  out  MW  SRAM port-0 byte mask.
REQ-024 SHALL have port sram_addr0  out  AW  SRAM port-0 address.
REQ-025 SHALL have port sram_din0  out  DW  SRAM port-0 write data.
REQ-026 SHALL have port sram_dout0  in  DW  SRAM port-0 read data.
REQ-027 SHALL have port sram_csb1  out  1  SRAM port-1 chip select, active-low.
REQ-028 SHALL have port sram_addr1  out  AW  SRAM port-1 address.
REQ-029 SHALL have port sram_dout1  in  DW  SRAM port-1 read data.

Function
REQ-030 SHALL arbitrate masters 0/1 onto SRAM port 0 round-robin: priority pointer moves to the other master after every grant; at most one grant per cycle.
REQ-031 SHALL treat master i as eligible when m_cmd_valid[i]=1 and outstanding count out[i] (granted, not yet popped; range 0..2) is <2, or ==2 with m_rsp_valid[i]&m_rsp_ready[i] in the same cycle.
REQ-032 SHALL assert m_cmd_ready[i] combinationally only for the granted master; a transfer occurs when valid&ready.
REQ-033 SHALL, in grant cycle N, drive sram_csb0=0, sram_web0=m_cmd_read[i], and addr/wdata/wmask of master i; with no grant, drive csb0=1, web0=1, wmask0=0.
REQ-034 SHALL capture sram_dout0 at the end of cycle N+1 for a granted read; write responses carry rdata=0.
REQ-035 SHALL present every response from cycle N+2 via a 2-entry per-master FIFO, in grant order, held stable until m_rsp_ready.
REQ-036 SHALL assert rd_cmd_ready when rd outstanding count <2 (or ==2 with a same-cycle rd pop), except in a hazard cycle.
REQ-037 SHALL define a hazard cycle as: port-0 write granted in the same cycle to the same address as rd_cmd_addr; rd_cmd_ready=0 for that cycle only.
REQ-038 SHALL, on rd accept in cycle N, drive sram_csb1=0 and sram_addr1=rd_cmd_addr; otherwise csb1=1.
REQ-039 SHALL capture sram_dout1 at the end of N+1 into a 2-entry rd response FIFO, with rd_rsp_valid from N+2.
REQ-040 SHALL allow a port-0 read and a port-1 read of the same address in the same cycle.
REQ-041 SHALL sustain one grant per cycle per channel when responses are popped every cycle.

Reset
REQ-042 SHALL, while rst=1, force m_cmd_ready=0, rd_cmd_ready=0, all rsp_valid=0, all rsp_rdata=0, csb0=csb1=1, web0=1, wmask0=0, addr0=addr1=0, din0=0.
REQ-043 SHALL, on reset assertion mid-operation, discard in-flight and buffered responses, clear all outstanding counts, and reset the priority pointer to master 0.

Verification
REQ-044 SHALL cover: m0 write addr 0x010, data 0xDEADBEEF, mask 0xF, then m0 read 0x010 -> write rsp at N+2 (rdata 0), read rsp rdata 0xDEADBEEF.
REQ-045 SHALL cover: both masters valid every cycle, rsp_ready=1 -> grants alternate m0,m1,m0,…, starting with m0 after reset.
REQ-046 SHALL cover: m1_rsp_ready=0 with 3 back-to-back m1 reads -> 2 accepted, third stalls until first pop, responses in order.
REQ-047 SHALL cover: m0 write 0x1FFF and rd read 0x1FFF in the same cycle -> rd_cmd_ready=0 for 1 cycle, then rd returns the new data.
REQ-048 SHALL cover: rst asserted with 2 responses buffered -> rsp_valid=0 immediately, csb0=csb1=1, no stale response after release.
